// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// LOADER_CHECKSUM_EN adds the CHECK state used by the checksum trailer.
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
// master = loader side, slave = byte source / RAM side.
interface instr_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k lands in bits [8k+7:8k].
// Independent of LOADER_CHECKSUM_EN.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full,
    output logic [1:0]  byte_idx
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        full_q;

    // clr resets only the index so the finished word stays readable
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (clr) begin
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (push) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_in;
            idx_q  <= idx_q + 2'd1;
            full_q <= (idx_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    assign word_out = word_q;
    assign full     = full_q;
    assign byte_idx = idx_q;

endmodule

// File: rtl/instr_loader.sv
// Loads a program into instruction RAM from a byte stream, holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte and drive err.
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_WIDTH:0] num_words,
    instr_loader_if.master      bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    loader_state_t         state, state_n;
    logic [ADDR_WIDTH:0]   count_q, wcnt_q, count_sat;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic                  in_ready_q, we_q, busy_q, done_q;
    logic                  start_acc, push, last_word, full;
    logic [1:0]            byte_idx;
    logic [31:0]           word;

    assign start_acc = (state == S_IDLE) && start;
    assign push      = (state == S_RECV) && in_ready_q && bus.in_valid;
    assign last_word = (wcnt_q + CNT_ONE) == count_q;
    assign count_sat = (num_words > DEPTH_W) ? DEPTH_W : num_words;

    byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc || full),
        .push     (push),
        .byte_in  (bus.in_data),
        .word_out (word),
        .full     (full),
        .byte_idx (byte_idx)
    );

`ifdef LOADER_CHECKSUM_EN
    logic       check_acc;
    logic [7:0] csum_q;
    logic       err_q;

    assign check_acc = (state == S_CHECK) && in_ready_q && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push)
                csum_q <= csum_q ^ bus.in_data;
            if (check_acc && (bus.in_data != csum_q))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = (count_sat == '0) ? S_DONE : S_RECV;
            S_RECV:  if (push && byte_idx == 2'(BYTES_PER_WORD - 1)) state_n = S_WRITE;
            S_WRITE: begin
                if (last_word)
`ifdef LOADER_CHECKSUM_EN
                    state_n = S_CHECK;
`else
                    state_n = S_DONE;
`endif
                else
                    state_n = S_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: if (check_acc) state_n = S_DONE;
`endif
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count_q    <= '0;
            wcnt_q     <= '0;
            waddr_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
`ifdef LOADER_CHECKSUM_EN
            in_ready_q <= (state_n == S_RECV) || (state_n == S_CHECK);
`else
            in_ready_q <= (state_n == S_RECV);
`endif
            we_q       <= (state_n == S_WRITE);
            busy_q     <= (state_n != S_IDLE);
            done_q     <= (state_n == S_DONE);
            if (start_acc) begin
                count_q <= count_sat;
                wcnt_q  <= '0;
                waddr_q <= '0;
            end else if (state == S_WRITE) begin
                wcnt_q  <= wcnt_q + CNT_ONE;
                waddr_q <= waddr_q + ADDR_ONE;
            end
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = word[DATA_WIDTH-1:0];
    assign busy         = busy_q;
    assign cpu_hold     = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (DEPTH = 16).
// Build with LOADER_CHECKSUM_EN to also exercise the checksum trailer.
module tb_instr_loader;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   num_words;
    logic          cpu_hold, busy, done, err;

    instr_loader_if #(.ADDR_WIDTH(AW)) bus ();

    instr_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .bus       (bus.master),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned    n_cmp = 0, n_mis = 0;
    int unsigned    cyc = 0, done_cnt = 0, hold_bad = 0, d0 = 0;
    logic [AW-1:0]  wa[$];
    logic [31:0]    wd[$];
    int unsigned    wc[$];
    logic [7:0]     csum;

    always @(negedge clk) begin
        cyc++;
        if (bus.we) begin
            wa.push_back(bus.waddr);
            wd.push_back(bus.wdata);
            wc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (cpu_hold !== busy) hold_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_write(input int unsigned k, input logic [AW-1:0] a, input logic [31:0] d);
        if (k < wa.size()) begin
            check($sformatf("waddr[%0d]", k), 32'(wa[k]), 32'(a));
            check($sformatf("wdata[%0d]", k), wd[k], d);
        end else begin
            check($sformatf("write_missing[%0d]", k), wa.size(), k + 1);
        end
    endtask

    function automatic logic [31:0] word_of(input int unsigned i);
        logic [7:0] v;
        v = 8'(i);
        return {8'h3C, ~v, 8'hA5, v};
    endfunction

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    // All driver tasks begin and end 1 time unit after a rising edge
    task automatic do_start(input logic [AW:0] n);
        start     = 1'b1;
        num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_load(input logic [AW:0] n);
        d0   = done_cnt;
        csum = '0;
        do_start(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'(ok), 1);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap);
            csum = csum ^ w[8*k +: 8];
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        @(posedge clk); #1;
        if (done_cnt == d0) check("done_timeout", done_cnt, d0 + 1);
    endtask

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 0);
`endif
        wait_done();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        num_words    = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_we",       32'(bus.we), 0);
        check("rst_waddr",    32'(bus.waddr), 0);
        check("rst_wdata",    bus.wdata, 0);
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(done), 0);
        check("rst_err",      32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Two words back to back
        clear_log();
        start_load(2);
        @(negedge clk);
        check("t1_busy",     32'(busy), 1);
        check("t1_cpu_hold", 32'(cpu_hold), 1);
        check("t1_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        finish_load();
        check("t1_we_count", wa.size(), 2);
        check_write(0, 0, 32'h0000_0013);
        check_write(1, 1, 32'h0010_0093);
        if (wc.size() >= 2) check("t1_word_spacing", wc[1] - wc[0], 5);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_err", 32'(err), 0);

        // One word with in_valid toggling
        clear_log();
        start_load(1);
        send_word(32'h0000_0013, 1);
        finish_load();
        check("t2_we_count", wa.size(), 1);
        check_write(0, 0, 32'h0000_0013);
        check("t2_done_count", done_cnt - d0, 1);

        // Zero-length load
        clear_log();
        start_load(0);
        @(negedge clk);
        check("t3_done_pulse", 32'(done), 1);
        check("t3_busy",       32'(busy), 1);
        @(negedge clk);
        check("t3_done_low",   32'(done), 0);
        check("t3_busy_low",   32'(busy), 0);
        @(posedge clk); #1;
        check("t3_we_count", wa.size(), 0);

        // Reset after 6 bytes of a 3-word load, with start in the same cycle
        clear_log();
        start_load(3);
        send_word(32'h0000_0013, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        rst   = 1'b1;
        start = 1'b1;
        num_words = 1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_in_ready", 32'(bus.in_ready), 0);
        check("t4_we",       32'(bus.we), 0);
        check("t4_waddr",    32'(bus.waddr), 0);
        check("t4_wdata",    bus.wdata, 0);
        check("t4_cpu_hold", 32'(cpu_hold), 0);
        check("t4_busy",     32'(busy), 0);
        check("t4_done",     32'(done), 0);
        check("t4_err",      32'(err), 0);
        check("t4_we_count", wa.size(), 1);
        check_write(0, 0, 32'h0000_0013);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_load(1);
        send_word(32'h0000_1237, 0);
        finish_load();
        check("t4_reload_count", wa.size(), 2);
        check_write(1, 0, 32'h0000_1237);

        // Oversized count saturates to DEPTH; a second start mid-load is ignored
        clear_log();
        start_load(AW'(0) + (AW+1)'(DEPTH + 5));
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == 3) do_start(1);
            send_word(word_of(i), 0);
        end
        finish_load();
        check("t5_we_count", wa.size(), DEPTH);
        for (int unsigned i = 0; i < DEPTH; i++) check_write(i, AW'(i), word_of(i));
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_busy_after", 32'(busy), 0);

`ifdef LOADER_CHECKSUM_EN
        // Correct then wrong checksum trailer
        clear_log();
        start_load(1);
        send_word(32'h0000_0013, 0);
        send_byte(8'h13, 0);
        wait_done();
        check("t6_err_good", 32'(err), 0);
        start_load(1);
        send_word(32'h0000_0013, 0);
        send_byte(8'h12, 0);
        wait_done();
        check("t6_err_bad", 32'(err), 1);
        repeat (4) begin @(posedge clk); #1; end
        check("t6_err_sticky", 32'(err), 1);
        start_load(0);
        @(negedge clk);
        check("t6_err_cleared", 32'(err), 0);
        @(posedge clk); #1;
        wait_done();
        check("t6_we_count", wa.size(), 2);
`endif

        check("hold_tracks_busy", hold_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
